// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: shifts a pattern into a CHAIN_LEN-cell scan chain, pulses one capture
// cycle, then shifts the response out. Optional MISR signature under `SCAN_MISR_EN`.
module scan_test_ctrl #(
  parameter int unsigned CHAIN_LEN = 8
) (
  input  logic                 C,
  input  logic                 global_reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 so,
  output logic                 NbarT,
  output logic                 Si,
  output logic                 CE,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response
`ifdef SCAN_MISR_EN
  ,
  output logic [CHAIN_LEN-1:0] signature
`endif
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CHAIN_LEN-1:0] MsbOnly = {1'b1, {(CHAIN_LEN-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StCapture,
    StShiftOut,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;

  logic                 cnt_last;
  logic [CHAIN_LEN-1:0] pat_shl;
  logic [CHAIN_LEN-1:0] out_mask;

  assign cnt_last = (cnt_q == LastCnt);
  // MSB-first serialisation: bit CHAIN_LEN-1-cnt ends up in the top position.
  assign pat_shl  = pat_q << cnt_q;
  assign out_mask = MsbOnly >> cnt_q;

  // State register
  always_ff @(posedge C) begin
    if (global_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge C) begin
    if (global_reset) begin
      cnt_q  <= '0;
      pat_q  <= '0;
      resp_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      resp_q <= resp_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    resp_d  = resp_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pat_d   = pattern;
          cnt_d   = '0;
          state_d = StShiftIn;
        end
      end
      StShiftIn: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        cnt_d   = '0;
        state_d = StShiftOut;
      end
      StShiftOut: begin
        // Chain tail arrives highest cell first.
        resp_d = so ? (resp_q | out_mask) : (resp_q & ~out_mask);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore outputs
  always_comb begin
    NbarT = 1'b0;
    Si    = 1'b0;
    CE    = 1'b0;
    done  = 1'b0;
    busy  = (state_q != StIdle);
    unique case (state_q)
      StIdle: ;
      StShiftIn: begin
        NbarT = 1'b1;
        Si    = pat_shl[CHAIN_LEN-1];
      end
      StCapture: begin
        CE = 1'b1;
      end
      StShiftOut: begin
        NbarT = 1'b1;
      end
      StDone: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign response = resp_q;

`ifdef SCAN_MISR_EN
  logic [CHAIN_LEN-1:0] sig_q;

  // Only completed tests fold into the signature; reset aborts never reach StDone.
  always_ff @(posedge C) begin
    if (global_reset) begin
      sig_q <= '0;
    end else if (state_q == StDone) begin
      sig_q <= {sig_q[CHAIN_LEN-2:0], sig_q[CHAIN_LEN-1]} ^ resp_q;
    end
  end

  assign signature = sig_q;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Directed bench for scan_test_ctrl driving an 8-cell chain of toggling dff cells.
module tb_scan_test_ctrl;

  logic       C = 1'b0;
  logic       global_reset;
  logic       start;
  logic [7:0] pattern;
  logic       so;
  logic       NbarT, Si, CE, busy, done;
  logic [7:0] response;
`ifdef SCAN_MISR_EN
  logic [7:0] signature;
`endif

  int checks = 0;
  int errors = 0;

  always #5 C = ~C;

  scan_test_ctrl #(.CHAIN_LEN(8)) dut (
    .C           (C),
    .global_reset(global_reset),
    .start       (start),
    .pattern     (pattern),
    .so          (so),
    .NbarT       (NbarT),
    .Si          (Si),
    .CE          (CE),
    .busy        (busy),
    .done        (done),
    .response    (response)
`ifdef SCAN_MISR_EN
    ,
    .signature   (signature)
`endif
  );

  // Chain of dff cells: scan shift when NbarT, functional D = ~Q when CE.
  logic [7:0] chain_q;
  always @(posedge C) begin
    if (global_reset) chain_q <= 8'h00;
    else if (NbarT)   chain_q <= {chain_q[6:0], Si};
    else if (CE)      chain_q <= ~chain_q;
  end
  assign so = chain_q[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full test; cycle i counts from the accepting edge. Optionally pulses start
  // with a different pattern mid shift-in, which must be ignored.
  task automatic run_test(input logic [7:0] pat, input logic [7:0] exp_resp, input bit inject);
    int ce_cnt;
    ce_cnt = 0;
    @(negedge C);
    start   = 1'b1;
    pattern = pat;
    @(negedge C);
    start = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      if (inject && i == 3) begin
        start   = 1'b1;
        pattern = 8'hFF;
      end else if (inject && i == 4) begin
        start = 1'b0;
      end
      if (i <= 8) chk("si", 32'(Si), 32'(pat[3'(8 - i)]));
      else        chk("si_zero", 32'(Si), 32'd0);
      chk("nbart", 32'(NbarT), 32'((i <= 8) || (i >= 10 && i <= 17)));
      chk("ce", 32'(CE), 32'(i == 9));
      chk("done", 32'(done), 32'(i == 18));
      chk("busy", 32'(busy), 32'd1);
      ce_cnt += int'(CE);
      if (i < 18) @(negedge C);
    end
    chk("response", 32'(response), 32'(exp_resp));
    chk("ce_count", 32'(ce_cnt), 32'd1);
    @(negedge C);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int last_k;
    int n_done;
    global_reset = 1'b1;
    start        = 1'b0;
    pattern      = 8'h00;

    // Reset state
    repeat (2) @(negedge C);
    chk("rst_nbart", 32'(NbarT), 32'd0);
    chk("rst_ce", 32'(CE), 32'd0);
    chk("rst_si", 32'(Si), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_resp", 32'(response), 32'h00);
    global_reset = 1'b0;

    // Basic test
    run_test(8'hA5, 8'h5A, 1'b0);

    // Start during shift-in ignored, then a fresh test
    run_test(8'hA5, 8'h5A, 1'b1);
    run_test(8'h00, 8'hFF, 1'b0);

    // Back-to-back tests with start held high
    @(negedge C);
    start   = 1'b1;
    pattern = 8'h3C;
    last_k  = -1;
    n_done  = 0;
    for (int k = 0; k < 80 && n_done < 3; k++) begin
      @(negedge C);
      if (done) begin
        chk("b2b_resp", 32'(response), 32'hC3);
        if (n_done > 0) chk("b2b_gap", 32'(k - last_k), 32'd19);
        last_k = k;
        n_done++;
        if (n_done == 3) start = 1'b0;
      end
    end
    chk("b2b_count", 32'(n_done), 32'd3);
    repeat (2) @(negedge C);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset on the 3rd shift-out cycle
    @(negedge C);
    start   = 1'b1;
    pattern = 8'hA5;
    @(negedge C);
    start = 1'b0;
    repeat (11) @(negedge C);
    chk("abort_shifting", 32'(NbarT), 32'd1);
    global_reset = 1'b1;
    @(negedge C);
    global_reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_nbart", 32'(NbarT), 32'd0);
    chk("abort_resp", 32'(response), 32'h00);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      n_done += int'(done);
      @(negedge C);
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    run_test(8'hA5, 8'h5A, 1'b0);

`ifdef SCAN_MISR_EN
    global_reset = 1'b1;
    repeat (2) @(negedge C);
    global_reset = 1'b0;
    chk("sig_rst", 32'(signature), 32'h00);
    run_test(8'hA5, 8'h5A, 1'b0);
    chk("sig_first", 32'(signature), 32'h5A);
    run_test(8'h3C, 8'hC3, 1'b0);
    chk("sig_second", 32'(signature), 32'h77);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
